// File: rtl/shift_deserializer_rx.sv
// LSB-first serial-to-parallel receiver with a held output word, valid/ready
// handshake and a sticky overrun flag for words dropped under backpressure.
module shift_deserializer_rx #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             clear,
    input  logic             ena,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shift_word;
    logic             complete;
    logic             consume;

    assign shift_word = {sin, q[WIDTH-1:1]};
    assign complete   = ena && (count == LAST);
    assign consume    = valid && ready;
    assign busy       = (count != '0);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            q       <= '0;
            count   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            q       <= '0;
            count   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (ena) begin
                q     <= shift_word;
                count <= complete ? '0 : count + CW'(1);
            end
            // A word completing while the old one is still unconsumed is dropped.
            if (complete) begin
                if (!valid || consume) begin
                    data  <= shift_word;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer_rx.sv
// Bench for shift_deserializer_rx: vector table, hand sequences for the corner
// cases, and a scoreboard that pairs each accepted word with its consume edge.
module tb_shift_deserializer_rx;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       clear;
    logic       ena;
    logic       sin;
    logic [3:0] q;
    logic       busy;
    logic [3:0] data;
    logic       valid;
    logic       ready;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] tx;      // tx[3] is sent first
        logic [3:0] exp_data;
    } vec_t;
    vec_t vecs[6];

    shift_deserializer_rx #(.WIDTH(4)) dut (
        .clk(clk), .areset_n(areset_n), .clear(clear), .ena(ena), .sin(sin),
        .q(q), .busy(busy), .data(data), .valid(valid), .ready(ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Consumer side of the scoreboard.
    always @(posedge clk) begin
        if (areset_n && !clear && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h expected=none", data);
            end else begin
                check("sb_data", data, exp_q.pop_front());
            end
        end
    end

    task automatic send_bit(input logic b);
        ena = 1'b1;
        sin = b;
        @(posedge clk);
        #1;
        ena = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] tx, input bit accept);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0 && accept) exp_q.push_back({tx[0], tx[1], tx[2], tx[3]});
            send_bit(tx[i]);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1011, 4'hD};
        vecs[1] = '{4'b0010, 4'h4};
        vecs[2] = '{4'b0110, 4'h6};
        vecs[3] = '{4'b1111, 4'hF};
        vecs[4] = '{4'b1000, 4'h1};
        vecs[5] = '{4'b0001, 4'h8};

        areset_n = 1'b0;
        clear = 1'b0;
        ena = 1'b0;
        sin = 1'b0;
        ready = 1'b0;
        #12;
        check("rst_q", q, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        areset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic word, continuous strobes
        ready = 1'b1;
        send_bit(1'b1); check("basic_q1", q, 4'b1000); check("basic_busy1", busy, 1);
        send_bit(1'b0); check("basic_q2", q, 4'b0100); check("basic_busy2", busy, 1);
        send_bit(1'b1); check("basic_q3", q, 4'b1010); check("basic_busy3", busy, 1);
        check("basic_valid_early", valid, 0);
        exp_q.push_back(4'hD);
        send_bit(1'b1);
        check("basic_busy4", busy, 0);
        check("basic_data", data, 4'hD);
        check("basic_valid", valid, 1);
        @(posedge clk);
        #1;
        check("basic_valid_drop", valid, 0);

        // Gapped strobes
        do_clear();
        send_bit(1'b1); repeat (3) @(posedge clk); #1; check("gap_q1", q, 4'b1000);
        send_bit(1'b0); repeat (3) @(posedge clk); #1; check("gap_q2", q, 4'b0100);
        send_bit(1'b1); repeat (3) @(posedge clk); #1; check("gap_q3", q, 4'b1010);
        check("gap_valid_early", valid, 0);
        check("gap_busy", busy, 1);
        exp_q.push_back(4'hD);
        send_bit(1'b1);
        check("gap_data", data, 4'hD);
        check("gap_valid", valid, 1);
        @(posedge clk);
        #1;

        // Table of back-to-back words with ready held high
        for (int v = 0; v < 6; v++) begin
            for (int i = 3; i >= 0; i--) begin
                if (i == 0) exp_q.push_back(vecs[v].exp_data);
                send_bit(vecs[v].tx[i]);
            end
            check("tbl_data", data, vecs[v].exp_data);
            check("tbl_valid", valid, 1);
        end
        @(posedge clk);
        #1;

        // Backpressure and overrun
        ready = 1'b0;
        send_word(4'b1011, 1'b1);
        send_word(4'b0110, 1'b0);
        check("bp_data", data, 4'hD);
        check("bp_valid", valid, 1);
        check("bp_overrun", overrun, 1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check("bp_valid_drop", valid, 0);
        check("bp_overrun_sticky", overrun, 1);
        check("bp_data_hold", data, 4'hD);
        do_clear();
        check("bp_overrun_clr", overrun, 0);

        // Completion and consume on the same edge
        send_word(4'b1011, 1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        ready = 1'b1;
        exp_q.push_back(4'h6);
        send_bit(1'b0);
        check("sim_data", data, 4'h6);
        check("sim_valid", valid, 1);
        check("sim_overrun", overrun, 0);
        @(posedge clk);
        #1;
        check("sim_valid_drop", valid, 0);

        // Asynchronous reset mid-word
        ready = 1'b0;
        send_bit(1'b1); send_bit(1'b1);
        #2;
        areset_n = 1'b0;
        #1;
        check("arst_q", q, 0);
        check("arst_busy", busy, 0);
        exp_q.delete();
        #1;
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(4'b0010, 1'b1);
        check("arst_data", data, 4'h4);
        check("arst_valid", valid, 1);
        ready = 1'b1;
        @(posedge clk);
        #1;

        // Clear beats a strobe and a pending word on the same edge
        ready = 1'b0;
        send_word(4'b1011, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        ready = 1'b1;
        ena = 1'b1;
        sin = 1'b1;
        do_clear();
        ena = 1'b0;
        check("clr_q", q, 0);
        check("clr_busy", busy, 0);
        check("clr_valid", valid, 0);
        send_word(4'b1111, 1'b1);
        check("clr_data", data, 4'hF);
        check("clr_valid2", valid, 1);
        @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
